// File: rtl/fft_iter_stream.sv
// fft_iter_stream: iterative radix-2 DIT FFT/IFFT engine.
// Samples stream in over a valid/ready handshake in bit-reversed placement.
// One shared butterfly per cycle then transforms the in-place array.
// Bins stream out in natural order over a second valid/ready handshake.
module fft_iter_stream #(
  parameter int N        = 32,
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16,
  parameter int SCALE    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_real,
  input  logic [WIDTH-1:0] in_imag,
  input  logic             inverse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_real,
  output logic [WIDTH-1:0] out_imag,
  output logic             out_last,
  output logic             busy
);

  localparam int LOG2N  = $clog2(N);
  localparam int HALF_N = N / 2;
  localparam int PW     = WIDTH + TW_WIDTH + 1;
  localparam int TW_MAX = 2 ** (TW_WIDTH - 1) - 1;
  localparam real PI    = 3.14159265358979323846;

  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] S_LAST   = LOG2N'(LOG2N - 1);
  localparam logic [LOG2N-1:0] S_ONE    = LOG2N'(1);
  localparam logic [LOG2N-2:0] B_LAST   = (LOG2N-1)'(HALF_N - 1);
  localparam logic [LOG2N-2:0] B_ONE    = (LOG2N-1)'(1);

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;

  state_t state_q, state_d;
  logic [LOG2N-1:0] c_q, u_q, s_q;
  logic [LOG2N-2:0] b_q;
  logic             inv_q;

  logic signed [WIDTH-1:0] mem_re [N];
  logic signed [WIDTH-1:0] mem_im [N];

  logic signed [TW_WIDTH-1:0] tw_cos [HALF_N];
  logic signed [TW_WIDTH-1:0] tw_sin [HALF_N];

  // Twiddle tables hold cos/sin(2*pi*k/N) rounded to nearest; +1.0 saturates.
  for (genvar g = 0; g < HALF_N; g++) begin : g_tw
    localparam real ANG   = 2.0 * PI * g / N;
    localparam real COS_R = $floor($cos(ANG) * (2.0 ** (TW_WIDTH - 1)) + 0.5);
    localparam real SIN_R = $floor($sin(ANG) * (2.0 ** (TW_WIDTH - 1)) + 0.5);
    localparam int  COS_I = (COS_R > TW_MAX) ? TW_MAX : $rtoi(COS_R);
    localparam int  SIN_I = (SIN_R > TW_MAX) ? TW_MAX : $rtoi(SIN_R);
    assign tw_cos[g] = TW_WIDTH'(COS_I);
    assign tw_sin[g] = TW_WIDTH'(SIN_I);
  end

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  logic load_hs, unload_hs, last_bfly;
  assign load_hs   = in_valid && (state_q == ST_LOAD);
  assign unload_hs = out_ready && (state_q == ST_UNLOAD);
  assign last_bfly = (s_q == S_LAST) && (b_q == B_LAST);

  // Butterfly addressing: stage s pairs elements half=2^s apart.
  logic [LOG2N-1:0] b_ext, half_m, pos, top_idx, bot_idx, s_p1, load_idx;
  logic [LOG2N-2:0] tw_idx;
  assign b_ext    = {1'b0, b_q};
  assign s_p1     = s_q + S_ONE;
  assign half_m   = S_ONE << s_q;
  assign pos      = b_ext & (half_m - S_ONE);
  assign top_idx  = ((b_ext >> s_q) << s_p1) | pos;
  assign bot_idx  = top_idx | half_m;
  assign tw_idx   = (LOG2N-1)'(pos << (S_LAST - s_q));
  assign load_idx = bitrev(c_q);

  logic signed [WIDTH-1:0]    top_re, top_im, bot_re, bot_im;
  logic signed [TW_WIDTH-1:0] w_re, w_im;
  logic signed [PW-1:0]       br_x, bi_x, wr_x, wi_x, prod_re, prod_im;
  logic signed [WIDTH:0]      p_re, p_im, top_re_x, top_im_x;
  logic signed [WIDTH:0]      sum_re, sum_im, dif_re, dif_im;
  logic signed [WIDTH-1:0]    new_top_re, new_top_im, new_bot_re, new_bot_im;

  assign top_re = mem_re[top_idx];
  assign top_im = mem_im[top_idx];
  assign bot_re = mem_re[bot_idx];
  assign bot_im = mem_im[bot_idx];

  // The inverse transform uses the conjugate twiddle.
  assign w_re = tw_cos[tw_idx];
  assign w_im = inv_q ? tw_sin[tw_idx] : -tw_sin[tw_idx];

  assign br_x = PW'(bot_re);
  assign bi_x = PW'(bot_im);
  assign wr_x = PW'(w_re);
  assign wi_x = PW'(w_im);
  assign prod_re = br_x * wr_x - bi_x * wi_x;
  assign prod_im = br_x * wi_x + bi_x * wr_x;

  assign p_re     = (WIDTH+1)'(prod_re >>> (TW_WIDTH - 1));
  assign p_im     = (WIDTH+1)'(prod_im >>> (TW_WIDTH - 1));
  assign top_re_x = (WIDTH+1)'(top_re);
  assign top_im_x = (WIDTH+1)'(top_im);
  assign sum_re   = top_re_x + p_re;
  assign sum_im   = top_im_x + p_im;
  assign dif_re   = top_re_x - p_re;
  assign dif_im   = top_im_x - p_im;

  assign new_top_re = (SCALE != 0) ? WIDTH'(sum_re >>> 1) : WIDTH'(sum_re);
  assign new_top_im = (SCALE != 0) ? WIDTH'(sum_im >>> 1) : WIDTH'(sum_im);
  assign new_bot_re = (SCALE != 0) ? WIDTH'(dif_re >>> 1) : WIDTH'(dif_re);
  assign new_bot_im = (SCALE != 0) ? WIDTH'(dif_im >>> 1) : WIDTH'(dif_im);

  assign out_real = mem_re[u_q];
  assign out_imag = mem_im[u_q];

  // Sample array: bit-reversed loading, then in-place butterfly write-back.
  always_ff @(posedge clk) begin
    if (load_hs) begin
      mem_re[load_idx] <= in_real;
      mem_im[load_idx] <= in_imag;
    end else if (state_q == ST_COMPUTE) begin
      mem_re[top_idx] <= new_top_re;
      mem_im[top_idx] <= new_top_im;
      mem_re[bot_idx] <= new_bot_re;
      mem_im[bot_idx] <= new_bot_im;
    end
  end

  // State register, load/unload/stage/butterfly counters and mode latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD;
      c_q     <= '0;
      u_q     <= '0;
      s_q     <= '0;
      b_q     <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_hs) begin
        c_q <= c_q + S_ONE;
        if (c_q == '0) inv_q <= inverse;
      end
      if (state_q == ST_COMPUTE) begin
        if (b_q == B_LAST) begin
          b_q <= '0;
          s_q <= (s_q == S_LAST) ? '0 : s_p1;
        end else begin
          b_q <= b_q + B_ONE;
        end
      end
      if (unload_hs) u_q <= u_q + S_ONE;
    end
  end

  // Next-state and handshake outputs for LOAD -> COMPUTE -> UNLOAD.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (load_hs && (c_q == IDX_LAST)) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        busy = 1'b1;
        if (last_bfly) state_d = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (u_q == IDX_LAST);
        if (unload_hs && (u_q == IDX_LAST)) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

endmodule

// File: tb/tb_fft_iter_stream.sv
// Bench for fft_iter_stream: two N=8 engines (SCALE=0 and SCALE=1) share
// the same input stream and are compared against a floating-point DFT.
module tb_fft_iter_stream;

  localparam int  N        = 8;
  localparam int  LOG2N    = 3;
  localparam int  WIDTH    = 16;
  localparam int  TW_WIDTH = 16;
  localparam real PI       = 3.14159265358979323846;
  // The saturated unity twiddle and floor rounding bias results negative by
  // up to ~1 LSB per product; these bounds cover that drift for N=8.
  localparam int  TOL0     = 10;
  localparam int  TOL1     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, in_valid, inverse, out_ready;
  logic [WIDTH-1:0] in_real, in_imag;
  logic             in_ready0, out_valid0, out_last0, busy0;
  logic             in_ready1, out_valid1, out_last1, busy1;
  logic [WIDTH-1:0] out_real0, out_imag0, out_real1, out_imag1;

  fft_iter_stream #(.N(N), .WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH), .SCALE(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_real(in_real), .in_imag(in_imag), .inverse(inverse),
    .out_valid(out_valid0), .out_ready(out_ready), .out_real(out_real0),
    .out_imag(out_imag0), .out_last(out_last0), .busy(busy0)
  );

  fft_iter_stream #(.N(N), .WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH), .SCALE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_real(in_real), .in_imag(in_imag), .inverse(inverse),
    .out_valid(out_valid1), .out_ready(out_ready), .out_real(out_real1),
    .out_imag(out_imag1), .out_last(out_last1), .busy(busy1)
  );

  int  n_checks = 0;
  int  n_pass   = 0;
  int  xr [N];
  int  xi [N];
  real mr [N];
  real mi [N];

  task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
    int diff;
    diff = observed - expected;
    if (diff < 0) diff = -diff;
    n_checks++;
    if (diff <= tol) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, observed, expected, tol);
  endtask

  function automatic int rnd(input real v);
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic int sx(input logic [WIDTH-1:0] v);
    return int'($signed(v));
  endfunction

  // Direct DFT of xr/xi; forward uses e^{-j..}, inverse e^{+j..}, no 1/N.
  task automatic computeModel(input bit inv);
    real ang, c, s, sr, si, sgn;
    sgn = inv ? 1.0 : -1.0;
    for (int m = 0; m < N; m++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = 2.0 * PI * real'(m * n) / real'(N);
        c   = $cos(ang);
        s   = sgn * $sin(ang);
        sr  = sr + real'(xr[n]) * c - real'(xi[n]) * s;
        si  = si + real'(xr[n]) * s + real'(xi[n]) * c;
      end
      mr[m] = sr;
      mi[m] = si;
    end
  endtask

  task automatic clearFrame();
    for (int n = 0; n < N; n++) begin
      xr[n] = 0;
      xi[n] = 0;
    end
  endtask

  task automatic randomFrame();
    for (int n = 0; n < N; n++) begin
      xr[n] = int'($urandom_range(3000)) - 1500;
      xi[n] = int'($urandom_range(3000)) - 1500;
    end
  endtask

  // Stream the frame in with a random valid duty; garbage rides on idle cycles.
  task automatic applyStimulus(input int valid_pct, input bit inv);
    int c, guard;
    bit v, rdy;
    c = 0;
    guard = 0;
    while (c < N && guard < 400) begin
      v        = ($urandom_range(99) < valid_pct);
      in_valid = v;
      in_real  = v ? WIDTH'(xr[c]) : WIDTH'($urandom);
      in_imag  = v ? WIDTH'(xi[c]) : WIDTH'($urandom);
      inverse  = (v && c == 0) ? inv : 1'($urandom);
      rdy      = in_ready0;
      @(posedge clk);
      #1;
      if (v && rdy) c++;
      guard++;
    end
    in_valid = 1'b0;
    checkOutput("load_count", c, N, 0);
  endtask

  // Wait for the result, then drain it with a random ready duty while
  // checking bins, out_last, stall stability and the return to LOAD.
  task automatic collectOutput(input int ready_pct, input int tol0, input int tol1, input bit check_lat);
    int lat, idx, guard, pr, pim;
    bit r, stalled;
    lat = 1;
    idx = 0;
    guard = 0;
    stalled = 1'b0;
    pr = 0;
    pim = 0;
    while (!out_valid0 && lat < 200) begin
      in_valid = 1'($urandom);
      in_real  = WIDTH'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    if (check_lat) checkOutput("latency", lat, (N / 2) * LOG2N + 1, 0);
    checkOutput("out_valid_seen", int'(out_valid0), 1, 0);
    while (idx < N && guard < 400 && out_valid0) begin
      r         = ($urandom_range(99) < ready_pct);
      out_ready = r;
      in_valid  = (idx < N - 1) ? 1'($urandom) : 1'b0;
      in_real   = WIDTH'($urandom);
      if (stalled) begin
        checkOutput("stall_re", sx(out_real0), pr, 0);
        checkOutput("stall_im", sx(out_imag0), pim, 0);
      end
      if (r) begin
        checkOutput($sformatf("s0_bin%0d_re", idx), sx(out_real0), rnd(mr[idx]), tol0);
        checkOutput($sformatf("s0_bin%0d_im", idx), sx(out_imag0), rnd(mi[idx]), tol0);
        checkOutput($sformatf("s1_bin%0d_re", idx), sx(out_real1), rnd(mr[idx] / N), tol1);
        checkOutput($sformatf("s1_bin%0d_im", idx), sx(out_imag1), rnd(mi[idx] / N), tol1);
        checkOutput($sformatf("last%0d", idx), int'(out_last0), int'(idx == N - 1), 0);
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pr  = sx(out_real0);
        pim = sx(out_imag0);
      end
      @(posedge clk);
      #1;
      guard++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("bin_count", idx, N, 0);
    checkOutput("ready_after", int'(in_ready0), 1, 0);
    checkOutput("busy_after", int'(busy0), 0, 0);
    checkOutput("valid_after", int'(out_valid1), 0, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit inv;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inverse   = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_in_ready", int'(in_ready0), 1, 0);
    checkOutput("rst_out_valid", int'(out_valid0), 0, 0);
    checkOutput("rst_out_last", int'(out_last0), 0, 0);
    checkOutput("rst_busy", int'(busy0), 0, 0);
    checkOutput("rst_busy1", int'(busy1), 0, 0);

    $display("[TB] impulse, forward");
    clearFrame();
    xr[0] = 1000;
    computeModel(1'b0);
    applyStimulus(100, 1'b0);
    collectOutput(100, 0, 0, 1'b0);

    $display("[TB] DC input, forward, latency");
    for (int n = 0; n < N; n++) xr[n] = 100;
    computeModel(1'b0);
    applyStimulus(100, 1'b0);
    collectOutput(100, TOL0, TOL1, 1'b1);

    $display("[TB] single tone, inverse then forward");
    clearFrame();
    xr[1] = 1000;
    computeModel(1'b1);
    applyStimulus(100, 1'b1);
    collectOutput(100, 2, TOL1, 1'b0);
    computeModel(1'b0);
    applyStimulus(100, 1'b0);
    collectOutput(100, 2, TOL1, 1'b0);

    $display("[TB] random frames, 30 percent duty");
    for (int f = 0; f < 5; f++) begin
      randomFrame();
      inv = 1'($urandom);
      computeModel(inv);
      applyStimulus(30, inv);
      collectOutput(30, TOL0, TOL1, 1'b0);
    end

    $display("[TB] reset during compute");
    randomFrame();
    applyStimulus(100, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("busy_mid_compute", int'(busy0), 1, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_in_ready", int'(in_ready0), 1, 0);
    checkOutput("abort_busy", int'(busy0), 0, 0);
    checkOutput("abort_out_valid", int'(out_valid0), 0, 0);
    randomFrame();
    inv = 1'($urandom);
    computeModel(inv);
    applyStimulus(30, inv);
    collectOutput(30, TOL0, TOL1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
